// File: rtl/disp_pkg.sv
// Shared display constants and types for the seven-segment scan path.
package disp_pkg;

    // Segment bus value with every segment (and the decimal point) dark.
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Active-low glyphs, bit order gfedcba, indexed by hex value 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Per-digit record captured once per frame.
    typedef struct packed {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
        logic       blink;
    } digit_snap_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low gfedcba glyph decoder.
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup into the shared glyph set.
    always_comb begin
        seg = GLYPHS[hex];
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with per-frame
// input snapshot, leading-zero suppression, PWM dimming, blink/blank and
// anti-ghosting dead time at the start of every digit slot.
module sseg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NDIG    = 8,
    parameter int SLOT_W  = 15,
    parameter int DEAD    = 4,
    parameter int BLINK_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NDIG-1:0]       hex_in,
    input  logic [NDIG-1:0]         dp_in,
    input  logic [NDIG-1:0]         blank_in,
    input  logic [NDIG-1:0]         blink_in,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [NDIG-1:0]         an,
    output logic [7:0]              sseg,
    output logic [$clog2(NDIG)-1:0] digit_idx,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NDIG);

    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [IDX_W-1:0]   scan_idx_r;
    logic [BLINK_W-1:0] frame_cnt_r;
    digit_snap_t        snap_r [NDIG];
    logic               lz_en_r;
    logic [3:0]         bright_r;

    logic               slot_end_s;
    logic               frame_start_s;
    logic [NDIG-1:0]    supp_s;
    logic               zero_run_s;
    digit_snap_t        cur_s;
    logic [6:0]         glyph_s;
    logic [3:0]         pwm_s;
    logic               on_s;
    logic [NDIG-1:0]    an_nxt_s;
    logic [7:0]         sseg_nxt_s;

    // Scan position decode: end of slot and the (digit 0, cycle 0) frame origin.
    always_comb begin
        slot_end_s    = (slot_cnt_r == {SLOT_W{1'b1}});
        frame_start_s = (scan_idx_r == {IDX_W{1'b0}}) && (slot_cnt_r == {SLOT_W{1'b0}});
    end

    // Slot, digit and frame counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_r  <= {SLOT_W{1'b0}};
            scan_idx_r  <= {IDX_W{1'b0}};
            frame_cnt_r <= {BLINK_W{1'b0}};
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
            if (slot_end_s) begin
                if (scan_idx_r == IDX_W'(NDIG - 1)) begin
                    scan_idx_r  <= {IDX_W{1'b0}};
                    frame_cnt_r <= frame_cnt_r + BLINK_W'(1);
                end else begin
                    scan_idx_r  <= scan_idx_r + IDX_W'(1);
                end
            end
        end
    end

    // Frame-coherent capture of all display inputs; taken inside dead time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NDIG; i++) begin
                snap_r[i] <= '0;
            end
            lz_en_r  <= 1'b0;
            bright_r <= 4'd0;
        end else if (frame_start_s) begin
            for (int i = 0; i < NDIG; i++) begin
                snap_r[i].hex   <= hex_in[4*i +: 4];
                snap_r[i].dp    <= dp_in[i];
                snap_r[i].blank <= blank_in[i];
                snap_r[i].blink <= blink_in[i];
            end
            lz_en_r  <= lz_en;
            bright_r <= bright;
        end else begin
            lz_en_r  <= lz_en_r;
            bright_r <= bright_r;
        end
    end

    // Leading-zero mask: walk from the top digit while every digit seen is zero.
    always_comb begin
        supp_s     = {NDIG{1'b0}};
        zero_run_s = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (snap_r[i].hex == 4'h0);
            if (i != 0) begin
                supp_s[i] = lz_en_r & zero_run_s;
            end else begin
                supp_s[i] = 1'b0;
            end
        end
    end

    // Select the captured record for the digit currently being scanned.
    always_comb begin
        cur_s = snap_r[scan_idx_r];
    end

    hex_to_sseg u_dec (
        .hex (cur_s.hex),
        .seg (glyph_s)
    );

    // Anode gating (dead time, PWM, blank, blink) and segment composition.
    always_comb begin
        pwm_s = slot_cnt_r[SLOT_W-1 -: 4];
        on_s  = (slot_cnt_r >= SLOT_W'(DEAD)) && (pwm_s <= bright_r) &&
                !cur_s.blank && !(cur_s.blink && frame_cnt_r[BLINK_W-1]);
        if (on_s) begin
            an_nxt_s   = ~({{(NDIG-1){1'b0}}, 1'b1} << scan_idx_r);
            sseg_nxt_s = {~cur_s.dp, (supp_s[scan_idx_r] ? 7'h7F : glyph_s)};
        end else begin
            an_nxt_s   = {NDIG{1'b1}};
            sseg_nxt_s = SSEG_OFF;
        end
    end

    // Registered pin drivers, one cycle behind the counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= {NDIG{1'b1}};
            sseg       <= SSEG_OFF;
            digit_idx  <= {IDX_W{1'b0}};
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt_s;
            sseg       <= sseg_nxt_s;
            digit_idx  <= scan_idx_r;
            frame_tick <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl (NDIG=4, SLOT_W=6, DEAD=2, BLINK_W=2).
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_en;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int errors;
    int checks;
    int cur_s;

    sseg_scan_ctrl #(
        .NDIG    (4),
        .SLOT_W  (6),
        .DEAD    (2),
        .BLINK_W (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .lz_en      (lz_en),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Hold reset across one rising edge, release on a falling edge.
    // After release, output state s is sampled at the falling edge after posedge s+1.
    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_s = -1;
    endtask

    task automatic go(input int s);
        while (cur_s < s) begin
            @(negedge clk);
            cur_s++;
        end
    endtask

    task automatic set_inputs(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] bk, input logic lz, input logic [3:0] br);
        hex_in = h; dp_in = dp; blank_in = bl; blink_in = bk; lz_en = lz; bright = br;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h expected %h", an, 4'hF); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg: got %h expected %h", sseg, 8'hFF); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    endtask

    task automatic test_basic_scan();
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [7:0] exp_seg [4];
        int ticks;
        int multi;
        one = 4'b0001;
        exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        ticks = 0;
        multi = 0;
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        restart();
        for (int s = 0; s < 512; s++) begin
            go(s);
            if (s % 64 < 2) exp_an = 4'hF;
            else exp_an = ~(one << ((s / 64) % 4));
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL scan_an s=%0d: got %b expected %b", s, an, exp_an); end
            if (exp_an != 4'hF) begin
                checks++;
                if (sseg !== exp_seg[(s / 64) % 4]) begin
                    errors++; $display("FAIL scan_sseg s=%0d: got %h expected %h", s, sseg, exp_seg[(s / 64) % 4]);
                end
            end else begin
                checks++;
                if (sseg !== 8'hFF) begin errors++; $display("FAIL dead_sseg s=%0d: got %h expected ff", s, sseg); end
            end
            checks++;
            if (digit_idx !== 2'((s / 64) % 4)) begin
                errors++; $display("FAIL scan_idx s=%0d: got %0d expected %0d", s, digit_idx, (s / 64) % 4);
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                checks++;
                if (s % 256 != 0) begin errors++; $display("FAIL tick_pos s=%0d: got pulse expected none", s); end
            end
            if ((an[0] + an[1] + an[2] + an[3]) < 3) multi++;
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL tick_count: got %0d expected 2", ticks); end
        checks++; if (multi != 0) begin errors++; $display("FAIL one_hot: got %0d cycles with >1 anode expected 0", multi); end
    endtask

    task automatic test_lz();
        set_inputs(16'h0030, 4'b1000, 4'h0, 4'h0, 1'b1, 4'd15);
        restart();
        go(2);
        checks++; if (sseg !== 8'hC0) begin errors++; $display("FAIL lz_d0: got %h expected c0", sseg); end
        go(66);
        checks++; if (sseg !== 8'hB0) begin errors++; $display("FAIL lz_d1: got %h expected b0", sseg); end
        go(130);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL lz_d2_an: got %b expected 1011", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL lz_d2: got %h expected ff", sseg); end
        go(194);
        checks++; if (sseg !== 8'h7F) begin errors++; $display("FAIL lz_d3: got %h expected 7f", sseg); end
        set_inputs(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 4'd15);
        restart();
        go(2);
        checks++; if (sseg !== 8'hC0) begin errors++; $display("FAIL lz0_d0: got %h expected c0", sseg); end
        go(66);
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL lz0_d1: got %h expected ff", sseg); end
        go(194);
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL lz0_d3: got %h expected ff", sseg); end
    endtask

    task automatic test_bright();
        int lows;
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 4'd3);
        restart();
        lows = 0;
        for (int s = 64; s < 128; s++) begin
            go(s);
            if (an === 4'b1101) lows++;
            if (s == 65 || s == 80 || s == 127) begin
                checks++; if (an !== 4'hF) begin errors++; $display("FAIL br3_off s=%0d: got %b expected 1111", s, an); end
            end
            if (s == 66 || s == 79) begin
                checks++; if (an !== 4'b1101) begin errors++; $display("FAIL br3_on s=%0d: got %b expected 1101", s, an); end
            end
        end
        checks++; if (lows != 14) begin errors++; $display("FAIL br3_duty: got %0d expected 14", lows); end
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0);
        restart();
        go(1);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL br0_s1: got %b expected 1111", an); end
        go(2);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL br0_s2: got %b expected 1110", an); end
        go(3);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL br0_s3: got %b expected 1110", an); end
        go(4);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL br0_s4: got %b expected 1111", an); end
    endtask

    task automatic test_blink_blank();
        logic [3:0] exp0 [5];
        exp0 = '{4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1110};
        set_inputs(16'h12AF, 4'h0, 4'b0100, 4'b0001, 1'b0, 4'd15);
        restart();
        for (int f = 0; f < 5; f++) begin
            go(f * 256 + 2);
            checks++;
            if (an !== exp0[f]) begin errors++; $display("FAIL blink_d0 f=%0d: got %b expected %b", f, an, exp0[f]); end
            if (f < 4) begin
                go(f * 256 + 66);
                checks++; if (an !== 4'b1101) begin errors++; $display("FAIL blink_d1 f=%0d: got %b expected 1101", f, an); end
                go(f * 256 + 140);
                checks++; if (an !== 4'hF) begin errors++; $display("FAIL blank_d2_an f=%0d: got %b expected 1111", f, an); end
                checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL blank_d2_seg f=%0d: got %h expected ff", f, sseg); end
            end
        end
    endtask

    task automatic test_snapshot();
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        restart();
        go(140);
        hex_in = 16'h3456;
        go(150);
        checks++; if (sseg !== 8'hA4) begin errors++; $display("FAIL snap_d2_old: got %h expected a4", sseg); end
        go(200);
        checks++; if (sseg !== 8'hF9) begin errors++; $display("FAIL snap_d3_old: got %h expected f9", sseg); end
        go(256);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL snap_tick: got %b expected 1", frame_tick); end
        go(258);
        checks++; if (sseg !== 8'h82) begin errors++; $display("FAIL snap_d0_new: got %h expected 82", sseg); end
        go(386);
        checks++; if (sseg !== 8'h99) begin errors++; $display("FAIL snap_d2_new: got %h expected 99", sseg); end
        go(450);
        checks++; if (sseg !== 8'hB0) begin errors++; $display("FAIL snap_d3_new: got %h expected b0", sseg); end
    endtask

    task automatic test_reset_mid();
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        restart();
        go(140);
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an: got %b expected 1011", an); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_an: got %b expected 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL mid_sseg: got %h expected ff", sseg); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL mid_idx: got %0d expected 0", digit_idx); end
        @(negedge clk);
        reset = 1'b0;
        cur_s = -1;
        go(0);
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL mid_tick: got %b expected 1", frame_tick); end
        checks++; if (digit_idx !== 2'd0) begin errors++; $display("FAIL mid_restart_idx: got %0d expected 0", digit_idx); end
        go(2);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_restart_an: got %b expected 1110", an); end
        checks++; if (sseg !== 8'h8E) begin errors++; $display("FAIL mid_restart_sseg: got %h expected 8e", sseg); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cur_s  = -1;
        reset  = 1'b1;
        set_inputs(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0);
        test_reset();
        test_basic_scan();
        test_lz();
        test_bright();
        test_blink_blank();
        test_snapshot();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

- Parametrised multiplexed seven-segment scan controller for the board display path.
- Drives NDIG common-anode digits from a packed hex bus and adds features the fixed 8-digit driver lacks:
  - per-digit blanking and blinking
  - leading-zero suppression
  - 16-level PWM brightness
  - anti-ghosting dead time
  - frame-coherent input snapshot
  - frame/digit status outputs
- Sits between the processor's debug/status registers and the board's anode/segment pins.

## Interface
- NDIG, 8: number of digits, 2..16.
- SLOT_W, 15: each digit slot lasts 2^SLOT_W cycles; must be ≥ 6.
- DEAD, 4: anode-off cycles at the start of every slot; 2 ≤ DEAD < 2^(SLOT_W-4).
- BLINK_W, 6: blink half-period is 2^(BLINK_W-1) frames; must be ≥ 1.
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- hex_in  in  4*NDIG  digit i is hex_in[4i+3:4i].
- dp_in  in  NDIG  1 = decimal point lit.
- blank_in  in  NDIG  1 = digit fully dark.
- blink_in  in  NDIG  1 = digit blinks.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  4  brightness: 0 = 1/16 duty, 15 = full duty.
- an  out  NDIG  anode enables, active-low, registered.
- sseg  out  8  active-low segments, registered. [6:0] = gfedcba, [7] = dp.
- digit_idx  out  $clog2(NDIG)  digit currently driven, registered.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

## Operation
- **Scan counters**
  - slot_cnt (SLOT_W bits) increments every cycle.
  - On terminal count, scan_idx advances; it wraps from NDIG-1 to 0.
  - Each wrap increments frame_cnt (BLINK_W bits), which wraps freely.
- **Snapshot**
  - When state is (scan_idx=0, slot_cnt=0), hex_in, dp_in, blank_in, blink_in, lz_en and bright are all captured.
  - Display logic uses only the captured values, so there is no mid-frame tearing.
  - Input changes take effect at the next frame.
- **Leading-zero suppression** (when the captured lz_en = 1)
  - Digit i > 0 is suppressed if its value and every higher digit's value are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows segments [6:0] off; its dp still follows dp_in.
- **Anode enable for slot i**
  - Asserted (low) only when all of the following hold:
    - slot_cnt ≥ DEAD
    - pwm = slot_cnt[SLOT_W-1:SLOT_W-4] ≤ bright
    - blank_i = 0
    - not (blink_i = 1 and frame_cnt[BLINK_W-1] = 1)
  - Otherwise an = all ones.
  - At most one anode is low at any time.
- **Segment output**
  - Decoder: 0..F map to the standard active-low glyphs; 0 = 1000000, F = 0001110.
  - sseg[7] = ~dp_i.
  - sseg = 8'hFF whenever an is all ones.

## Timing
- an, sseg, digit_idx and frame_tick are registered.
- They reflect the counter state of the previous cycle (1-cycle latency).
- frame_tick is high for exactly one cycle per frame, in the cycle whose outputs correspond to state (0,0).
- Frame period is NDIG·2^SLOT_W cycles. Defaults give 262144 cycles, about 190 Hz at 50 MHz.
- **Reset (asynchronous)**
  - an = all ones, sseg = 8'hFF, digit_idx = 0, frame_tick = 0.
  - All counters and snapshot registers are cleared to 0.
  - The snapshot is taken on the first clock after reset release.
- **Reset mid-slot**: all outputs go dark immediately; scanning restarts at digit 0.
- Snapshot capture coincides with dead time, so the new values are never displayed in a partial slot.
- bright = 15 gives duty (2^SLOT_W − DEAD)/2^SLOT_W.
- bright = 0 gives anode-on for slot_cnt in [DEAD, 2^(SLOT_W-4)−1].

## Structure
- Package disp_pkg holds:
  - the SSEG_OFF = 8'hFF constant
  - the 16-entry glyph constant array
  - a typedef for the per-digit snapshot record (hex, dp, blank, blink).
- Sub-module hex_to_sseg: purely combinational 4-bit → 7-bit decoder using the package glyphs.
- Counters, snapshot, suppression, PWM and blink logic all live in sseg_scan_ctrl.

## Test plan
The bench uses NDIG=4, SLOT_W=6, DEAD=2, BLINK_W=2.
- **Basic scan**
  - Stimulus: hex_in = 16'h12AF, bright = 15, everything else 0.
  - an cycles 1110 → 1101 → 1011 → 0111, 64 cycles each.
  - sseg for digit 0 = 8'h8E (F); for digit 3 = 8'hF9 (1).
  - frame_tick pulses every 256 cycles.
  - an = 1111 for the first 2 output cycles of each slot.
- **Leading-zero suppression**
  - Stimulus: hex_in = 16'h0030, lz_en = 1, dp_in = 4'b1000.
  - Digits 2 and 3 show sseg[6:0] = 7F; digit 3 shows sseg = 8'h7F (dp lit).
  - Digit 1 shows 3; digit 0 shows 0.
  - With hex_in = 0, only digit 0 lights.
- **Brightness**
  - Stimulus: bright = 3.
  - Each slot has anode low for output cycles 2..15 and high for 16..63.
  - With bright = 0, anode is low for cycles 2..3 only.
- **Blink and blank**
  - Stimulus: blink_in = 4'b0001, blank_in = 4'b0100.
  - Digit 2 is never lit.
  - Digit 0 is lit in frames with frame_cnt[1] = 0 and dark for two frames in alternation.
- **Snapshot coherence**
  - Stimulus: change hex_in during digit 2's slot.
  - Digits 2 and 3 keep the old values until frame_tick; new values appear in the next frame.
- **Reset mid-operation**
  - Stimulus: assert reset during digit 2's PWM-on phase.
  - an = 1111 and sseg = FF with no clock edge.
  - After release, scanning restarts at digit 0 and frame_tick fires on the first output cycle.
